// File: rtl/fwd_select_tracker.sv
// -----------------------------------------------------------------------------
// fwd_select_tracker
//
// Forwarding-control stage for the pipelined CPU. It follows the destination
// registers of in-flight instructions through EX, MEM, WB (and WB+1 when
// FWD_WB2_EN is defined). It produces registered 2-bit operand-mux selects
// that are valid for the whole EX cycle of the instruction they belong to.
//
// Select codes:
//   0  register-file data
//   1  EX/MEM ALU result
//   2  MEM/WB writeback data
//   3  WB+1 delayed writeback data
//      Produced only with FWD_WB2_EN defined. Without the macro the register
//      file is write-through, so a WB-stage producer needs no forwarding.
//
// Optional feature macro: FWD_WB2_EN
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous reset, active-high
//   stall_i        ID holds its instruction; a bubble enters EX
//   flush_i        ID instruction discarded; a bubble enters EX
//   id_rs_i        ID source register A
//   id_rt_i        ID source register B
//   id_rd_i        ID destination register
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   fwd_a_sel_o    operand-A select for the current EX instruction
//   fwd_b_sel_o    operand-B select for the current EX instruction
//   load_use_o     combinational load-use hazard for the ID instruction
// -----------------------------------------------------------------------------
module fwd_select_tracker #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              load_use_o
);

  // A record forwards only if its valid bit is set. The valid bit already
  // excludes register 0, so only the source needs an explicit zero test.
  function automatic logic src_hit(input logic              vld,
                                   input logic [ADDR_W-1:0] rd,
                                   input logic [ADDR_W-1:0] src);
    return vld && (src != '0) && (rd == src);
  endfunction

  // The newest producer wins.
  function automatic logic [1:0] pick_sel(input logic hit_ex,
                                          input logic hit_mem,
                                          input logic hit_wb);
    if (hit_ex)       return 2'd1;
    else if (hit_mem) return 2'd2;
    else if (hit_wb)  return 2'd3;
    else              return 2'd0;
  endfunction

  logic              issue;
  logic              id_vld;

  logic              rec_vld_p0;
  logic [ADDR_W-1:0] rec_rd_p0;
  logic              rec_mrd_p0;
  logic              rec_vld_p1;
  logic [ADDR_W-1:0] rec_rd_p1;

  logic              hit_a_wb;
  logic              hit_b_wb;
  logic [1:0]        sel_a_nxt;
  logic [1:0]        sel_b_nxt;

  assign issue  = !(stall_i || flush_i);
  assign id_vld = id_regwrite_i && (id_rd_i != '0);

`ifdef FWD_WB2_EN
  logic              rec_vld_p2;
  logic [ADDR_W-1:0] rec_rd_p2;
  logic              rec_vld_p3;
  logic [ADDR_W-1:0] rec_rd_p3;

  assign hit_a_wb = src_hit(rec_vld_p2, rec_rd_p2, id_rs_i);
  assign hit_b_wb = src_hit(rec_vld_p2, rec_rd_p2, id_rt_i);
`else
  // The register file is write-through: a WB-stage producer is already
  // visible on the register-file read port.
  assign hit_a_wb = 1'b0;
  assign hit_b_wb = 1'b0;
`endif

  assign sel_a_nxt = pick_sel(src_hit(rec_vld_p0, rec_rd_p0, id_rs_i),
                              src_hit(rec_vld_p1, rec_rd_p1, id_rs_i),
                              hit_a_wb);
  assign sel_b_nxt = pick_sel(src_hit(rec_vld_p0, rec_rd_p0, id_rt_i),
                              src_hit(rec_vld_p1, rec_rd_p1, id_rt_i),
                              hit_b_wb);

  // A load in EX blocks any ID instruction that reads its destination.
  // The valid bit of the EX record already guarantees rd != 0.
  assign load_use_o = rec_vld_p0 && rec_mrd_p0 &&
                      (((rec_rd_p0 == id_rs_i) && (id_rs_i != '0)) ||
                       ((rec_rd_p0 == id_rt_i) && (id_rt_i != '0)));

  // ID -> EX: the EX record and the selects for the instruction entering EX.
  // A bubble clears both the record valid bit and the selects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_vld_p0  <= 1'b0;
      fwd_a_sel_o <= 2'd0;
      fwd_b_sel_o <= 2'd0;
    end else if (issue) begin
      rec_vld_p0  <= id_vld;
      fwd_a_sel_o <= sel_a_nxt;
      fwd_b_sel_o <= sel_b_nxt;
    end else begin
      rec_vld_p0  <= 1'b0;
      fwd_a_sel_o <= 2'd0;
      fwd_b_sel_o <= 2'd0;
    end
  end

  // The register and load fields are qualified by the valid bits, so they
  // are loaded every cycle and are not reset.
  always_ff @(posedge clk_i) begin
    rec_rd_p0  <= id_rd_i;
    rec_mrd_p0 <= id_memread_i;
  end

  // EX -> MEM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rec_vld_p1 <= 1'b0;
    else       rec_vld_p1 <= rec_vld_p0;
  end

  always_ff @(posedge clk_i) begin
    rec_rd_p1 <= rec_rd_p0;
  end

`ifdef FWD_WB2_EN
  // MEM -> WB and WB -> WB+1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_vld_p2 <= 1'b0;
      rec_vld_p3 <= 1'b0;
    end else begin
      rec_vld_p2 <= rec_vld_p1;
      rec_vld_p3 <= rec_vld_p2;
    end
  end

  always_ff @(posedge clk_i) begin
    rec_rd_p2 <= rec_rd_p1;
    rec_rd_p3 <= rec_rd_p2;
  end
`endif

endmodule

// File: tb/tb_fwd_select_tracker.sv
module tb_fwd_select_tracker;

  localparam int ADDR_W = 5;

`ifdef FWD_WB2_EN
  localparam logic [1:0] SEL_D3 = 2'd3;
`else
  localparam logic [1:0] SEL_D3 = 2'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              load_use;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {sel_a, sel_b} of each presented instruction, pushed when the
  // instruction is driven and popped once it has reached EX.
  logic [3:0] exp_q[$];

  fwd_select_tracker #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rd_i      (id_rd),
    .id_regwrite_i(id_regwrite),
    .id_memread_i (id_memread),
    .fwd_a_sel_o  (fwd_a_sel),
    .fwd_b_sel_o  (fwd_b_sel),
    .load_use_o   (load_use)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs,
                           input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Present one ID instruction. load_use is checked before the edge; the
  // selects are checked one cycle later, when the instruction sits in EX.
  task automatic step(input string tag,
                      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                      input logic [ADDR_W-1:0] rd, input logic rw,
                      input logic mr, input logic st, input logic fl,
                      input logic elu, input logic [1:0] ea,
                      input logic [1:0] eb);
    logic [3:0] e;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; stall = st; flush = fl;
    exp_q.push_back({ea, eb});
    #1;
    check_val({tag, ".load_use"}, {7'd0, load_use}, {7'd0, elu});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".sel_a"}, {6'd0, fwd_a_sel}, {6'd0, e[3:2]});
      check_val({tag, ".sel_b"}, {6'd0, fwd_b_sel}, {6'd0, e[1:0]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset.sel_a", {6'd0, fwd_a_sel}, 8'd0);
    check_val("reset.sel_b", {6'd0, fwd_b_sel}, 8'd0);
    check_val("reset.load_use", {7'd0, load_use}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    //        tag         rs  rt  rd  rw mr st fl lu  a  b
    // Back-to-back dependence.
    step("b2b.prod",    0,  0,  3, 1, 0, 0, 0, 0, 0, 0);
    step("b2b.cons",    3,  4, 10, 1, 0, 0, 0, 0, 1, 0);
    // Distance 2.
    step("d2.prod",     0,  0,  5, 1, 0, 0, 0, 0, 0, 0);
    step("d2.gap",      1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
    step("d2.cons",     5,  0,  0, 0, 0, 0, 0, 0, 2, 0);
    // Distance 3.
    step("d3.prod",     0,  0,  6, 1, 0, 0, 0, 0, 0, 0);
    step("d3.gap1",     1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
    step("d3.gap2",     1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
    step("d3.cons",     6,  0,  0, 0, 0, 0, 0, 0, SEL_D3, 0);
    // Priority: the distance-1 producer beats the distance-3 producer.
    step("prio.old",    0,  0,  7, 1, 0, 0, 0, 0, 0, 0);
    step("prio.gap",    1,  2,  0, 0, 0, 0, 0, 0, 0, 0);
    step("prio.new",    0,  0,  7, 1, 0, 0, 0, 0, 0, 0);
    step("prio.cons",   0,  7,  0, 0, 0, 0, 0, 0, 0, 1);
    // Load-use: stall one cycle, then issue with sel 2.
    step("lu.load",     0,  0,  8, 1, 1, 0, 0, 0, 0, 0);
    step("lu.stall",    8,  0, 11, 1, 0, 1, 0, 1, 0, 0);
    step("lu.issue",    8,  0, 11, 1, 0, 0, 0, 0, 2, 0);
    // Register 0 never forwards.
    step("r0.prod",     0,  0,  0, 1, 0, 0, 0, 0, 0, 0);
    step("r0.cons",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0);
    // Flush: the bubble gets sel 0 and the flushed producer is dropped.
    step("fl.prod",     0,  0,  9, 1, 0, 0, 0, 0, 0, 0);
    step("fl.flush",    9,  0, 12, 1, 0, 0, 1, 0, 0, 0);
    step("fl.cons",     9, 12,  0, 0, 0, 0, 0, 0, 2, 0);
    // Stall and flush together behave as a flush.
    step("sf.prod",     0,  0, 13, 1, 0, 0, 0, 0, 0, 0);
    step("sf.both",    13,  0, 14, 1, 0, 1, 1, 0, 0, 0);
    step("sf.cons",    13, 14,  0, 0, 0, 0, 0, 0, 2, 0);
    // Nonzero selects just before an asynchronous reset.
    step("ar.prod",     0,  0,  3, 1, 0, 0, 0, 0, 0, 0);
    step("ar.cons",     3,  3,  0, 0, 0, 0, 0, 0, 1, 1);

    // Assert reset between clock edges; the selects must clear at once.
    #2;
    rst = 1'b1;
    #1;
    check_val("areset.sel_a", {6'd0, fwd_a_sel}, 8'd0);
    check_val("areset.sel_b", {6'd0, fwd_b_sel}, 8'd0);
    check_val("areset.load_use", {7'd0, load_use}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post.cons",   3,  0,  0, 0, 0, 0, 0, 0, 0, 0);

    check_val("queue.empty", exp_q.size(), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
